// File: rtl/gg_pkg.sv
// rtl/gg_pkg.sv - shared types, register indices and letter map for the Game Genie loader
package gg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_WRITE,
        ST_CLEAR
    } gg_state_t;

    localparam logic [1:0] GG_ADDR_LO = 2'd0;
    localparam logic [1:0] GG_ADDR_HI = 2'd1;
    localparam logic [1:0] GG_CMP     = 2'd2;
    localparam logic [1:0] GG_VAL     = 2'd3;

    // Returns {valid, nibble}; lower-case letters are folded to upper case first.
    function automatic logic [4:0] gg_char_nibble(input logic [7:0] c);
        logic [7:0] u;
        logic [4:0] r;
        u = (c >= 8'h61 && c <= 8'h7a) ? (c - 8'h20) : c;
        case (u)
            8'h41: r = 5'h10; // A
            8'h50: r = 5'h11; // P
            8'h5a: r = 5'h12; // Z
            8'h4c: r = 5'h13; // L
            8'h47: r = 5'h14; // G
            8'h49: r = 5'h15; // I
            8'h54: r = 5'h16; // T
            8'h59: r = 5'h17; // Y
            8'h45: r = 5'h18; // E
            8'h4f: r = 5'h19; // O
            8'h58: r = 5'h1a; // X
            8'h55: r = 5'h1b; // U
            8'h4b: r = 5'h1c; // K
            8'h53: r = 5'h1d; // S
            8'h56: r = 5'h1e; // V
            8'h4e: r = 5'h1f; // N
            default: r = 5'h00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gg_code_loader_lut.sv
// rtl/gg_code_loader_lut.sv - combinational ASCII letter to nibble lookup
import gg_pkg::*;

module gg_letter_lut (
    input  logic [7:0] in_char,
    output logic       valid,
    output logic [3:0] nibble
);

    // Pure decode of the incoming character.
    always_comb begin
        {valid, nibble} = gg_char_nibble(in_char);
    end

endmodule

// File: rtl/gg_code_loader.sv
// rtl/gg_code_loader.sv - decodes Game Genie letter streams into cheat-slot register writes
import gg_pkg::*;

module gg_code_loader #(
    parameter int CHEAT_NUM = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    input  logic       in_last,
    input  logic [5:0] in_slot,
    input  logic       clr_all,
    output logic       wr_we,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [6:0] NUM7 = 7'(CHEAT_NUM);

    gg_state_t  state;
    logic [3:0] nib [8];
    logic [3:0] cnt;
    logic [5:0] slot;
    logic       bad_q, len_q, reject_q;
    logic [15:0] a_q;
    logic [7:0] c_q, v_q;
    logic [6:0] idx;

    logic       lut_valid;
    logic [3:0] lut_nib;
    logic       accept, first, bad_next, len_next, reject_next;
    logic [3:0] cnt_next;
    logic [15:0] a_dec;
    logic [7:0] c_dec, v_dec;
    logic [3:0] nl;

    gg_letter_lut u_lut (
        .in_char (in_char),
        .valid   (lut_valid),
        .nibble  (lut_nib)
    );

    // clr_all takes priority in IDLE, so the letter must not be handshaken that cycle.
    always_comb begin
        in_ready = !rst && (state == ST_COLLECT || (state == ST_IDLE && !clr_all));
    end

    // Flag and count updates for the letter being accepted, including the one marked last.
    always_comb begin
        accept      = in_valid && in_ready;
        first       = (state == ST_IDLE);
        bad_next    = (first ? 1'b0 : bad_q) | ~lut_valid |
                      (first && ({1'b0, in_slot} >= NUM7));
        len_next    = (first ? 1'b0 : len_q) | (!first && cnt == 4'd8);
        cnt_next    = first ? 4'd1 : ((cnt == 4'd8) ? 4'd8 : cnt + 4'd1);
        reject_next = bad_next | len_next | !(cnt_next == 4'd6 || cnt_next == 4'd8);
    end

    // Address / compare / value scramble from the stored letters.
    always_comb begin
        nl    = (cnt == 4'd8) ? nib[7] : nib[5];
        a_dec = 16'h8000
              | (16'(nib[3] & 4'h7) << 12) | (16'(nib[5] & 4'h7) << 8)
              | (16'(nib[4] & 4'h8) << 8)  | (16'(nib[2] & 4'h7) << 4)
              | (16'(nib[1] & 4'h8) << 4)  | 16'(nib[4] & 4'h7)
              | 16'(nib[3] & 4'h8);
        v_dec = (8'(nib[1] & 4'h7) << 4) | (8'(nib[0] & 4'h8) << 4)
              | 8'(nib[0] & 4'h7) | 8'(nl & 4'h8);
        c_dec = (cnt == 4'd8) ?
                ((8'(nib[7] & 4'h7) << 4) | (8'(nib[6] & 4'h8) << 4)
                | 8'(nib[6] & 4'h7) | 8'(nib[5] & 4'h8)) : v_dec;
    end

    // Main control FSM; the slot is disabled first and re-enabled last so it never runs half-written.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            slot     <= '0;
            bad_q    <= 1'b0;
            len_q    <= 1'b0;
            reject_q <= 1'b0;
            a_q      <= '0;
            c_q      <= '0;
            v_q      <= '0;
            idx      <= '0;
            wr_we    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            for (int i = 0; i < 8; i++) nib[i] <= '0;
        end else begin
            wr_we <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            case (state)
                ST_IDLE, ST_COLLECT: begin
                    if (state == ST_IDLE && clr_all) begin
                        wr_we   <= 1'b1;
                        wr_addr <= {6'd0, GG_ADDR_HI};
                        wr_data <= 8'h00;
                        idx     <= 7'd1;
                        busy    <= 1'b1;
                        state   <= ST_CLEAR;
                    end else if (accept) begin
                        if (first) begin
                            slot   <= in_slot;
                            nib[0] <= lut_nib;
                        end else if (cnt < 4'd8) begin
                            nib[cnt[2:0]] <= lut_nib;
                        end
                        cnt   <= cnt_next;
                        bad_q <= bad_next;
                        len_q <= len_next;
                        if (in_last) begin
                            err      <= reject_next;
                            reject_q <= reject_next;
                            busy     <= 1'b1;
                            state    <= ST_CHECK;
                        end else begin
                            state <= ST_COLLECT;
                        end
                    end else if (state == ST_IDLE) begin
                        cnt   <= '0;
                        bad_q <= 1'b0;
                        len_q <= 1'b0;
                        for (int i = 0; i < 8; i++) nib[i] <= '0;
                    end
                end
                ST_CHECK: begin
                    if (reject_q) begin
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        a_q     <= a_dec;
                        c_q     <= c_dec;
                        v_q     <= v_dec;
                        wr_we   <= 1'b1;
                        wr_addr <= {slot, GG_ADDR_HI};
                        wr_data <= 8'h00;
                        idx     <= 7'd1;
                        state   <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    idx <= idx + 7'd1;
                    case (idx[2:0])
                        3'd1: begin wr_we <= 1'b1; wr_addr <= {slot, GG_ADDR_LO}; wr_data <= a_q[7:0]; end
                        3'd2: begin wr_we <= 1'b1; wr_addr <= {slot, GG_CMP};     wr_data <= c_q;      end
                        3'd3: begin wr_we <= 1'b1; wr_addr <= {slot, GG_VAL};     wr_data <= v_q;      end
                        3'd4: begin wr_we <= 1'b1; wr_addr <= {slot, GG_ADDR_HI}; wr_data <= a_q[15:8]; end
                        default: begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end
                    endcase
                end
                ST_CLEAR: begin
                    if (idx == NUM7) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        wr_we   <= 1'b1;
                        wr_addr <= {idx[5:0], GG_ADDR_HI};
                        wr_data <= 8'h00;
                        idx     <= idx + 7'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
